fracdiv_cfg_ctrl: RTL and testbench

Configuration sequencer for the fractional clock divider (ratio M/N, SDM-gated counter). Accepts new (m, n) requests over a valid/ready handshake and drives the divider's m/n inputs so that changes land only at safe points (divider output toggle, where the divider's counter has just cleared). A change to m is slewed toward the target in bounded steps, avoiding abrupt output-frequency jumps. Sits between the register/control interface and the divider, in the clk_fast domain.

---
 rtl/fracdiv_pkg.sv | 14 +
 rtl/fracdiv_edge_tmo.sv | 47 ++++
 rtl/fracdiv_cfg_ctrl.sv | 142 ++++++++++++++
 tb/tb_fracdiv_cfg_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fracdiv_pkg.sv
// rtl/fracdiv_pkg.sv - shared types and reset defaults for the fractional divider config path
package fracdiv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        RAMP      = 2'd2,
        DONE      = 2'd3
    } fracdiv_state_t;

    localparam int M_INIT_DEF = 99;
    localparam int N_INIT_DEF = 32'h0000_8000;

endpackage

// File: rtl/fracdiv_edge_tmo.sv
// rtl/fracdiv_edge_tmo.sv - divider toggle detector with stall timeout
//
// Ports:
//   clk_fast    in   divider fast clock
//   rst_n       in   asynchronous active-low reset
//   div_clk     in   divider clk_out, already synchronous to clk_fast
//   en          in   events are only wanted while the controller is waiting on the divider
//   step_evt    out  toggle seen, or timeout standing in for one
//   timeout_evt out  one-cycle pulse when the counter expires without a toggle
module fracdiv_edge_tmo #(
    parameter int TMO_LEN = 20
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic div_clk,
    input  logic en,
    output logic step_evt,
    output logic timeout_evt
);

    logic               div_clk_d;
    logic [TMO_LEN-1:0] tmo_cnt;
    logic               toggle;

    // Both divider edges count as a safe point.
    assign toggle      = div_clk ^ div_clk_d;
    assign timeout_evt = en && (tmo_cnt == '1);
    assign step_evt    = en && (toggle || timeout_evt);

    // Holding the counter at zero while disabled means every entry into an
    // active state starts a fresh timeout window; the transition into RAMP
    // happens on a step event, which clears it as well.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            div_clk_d <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            div_clk_d <= div_clk;
            if (!en || step_evt) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fracdiv_cfg_ctrl.sv
// rtl/fracdiv_cfg_ctrl.sv - sequences (m, n) updates into the fractional divider at safe points
//
// Ports:
//   clk_fast    in   divider fast clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   new configuration request
//   req_ready   out  controller can accept a request
//   req_m       in   target m
//   req_n       in   target n
//   div_clk     in   divider clk_out fed back
//   m_out       out  m driven to the divider, slewed toward the target
//   n_out       out  n driven to the divider, changed once per request
//   busy        out  request in progress
//   done        out  one-cycle pulse when the target is fully applied
//   timeout_evt out  one-cycle pulse when a timeout substitutes for a toggle
module fracdiv_cfg_ctrl
    import fracdiv_pkg::*;
#(
    parameter int              MLEN       = 16,
    parameter int              NLEN       = 16,
    parameter logic [MLEN-1:0] M_INIT     = MLEN'(M_INIT_DEF),
    parameter logic [NLEN-1:0] N_INIT     = NLEN'(N_INIT_DEF),
    parameter int              STEP       = 1,
    parameter int              HOLD_EDGES = 2,
    parameter int              TMO_LEN    = 20
) (
    input  logic            clk_fast,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [MLEN-1:0] req_m,
    input  logic [NLEN-1:0] req_n,
    input  logic            div_clk,
    output logic [MLEN-1:0] m_out,
    output logic [NLEN-1:0] n_out,
    output logic            busy,
    output logic            done,
    output logic            timeout_evt
);

    localparam int               HW        = $clog2(HOLD_EDGES + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_EDGES - 1);
    localparam logic [MLEN:0]    STEP_X    = (MLEN + 1)'(STEP);

    fracdiv_state_t         state;
    logic [MLEN-1:0]        tgt_m;
    logic [NLEN-1:0]        tgt_n;
    logic [HW-1:0]          hold_cnt;
    logic                   step_evt;
    logic                   tmo_en;

    logic signed [MLEN:0]   diff;
    logic [MLEN:0]          mag;
    logic [MLEN:0]          step_amt;
    logic [MLEN-1:0]        m_next;

    assign tmo_en = (state == WAIT_EDGE) || (state == RAMP);

    fracdiv_edge_tmo #(
        .TMO_LEN (TMO_LEN)
    ) u_edge_tmo (
        .clk_fast    (clk_fast),
        .rst_n       (rst_n),
        .div_clk     (div_clk),
        .en          (tmo_en),
        .step_evt    (step_evt),
        .timeout_evt (timeout_evt)
    );

    // One extra bit keeps the distance exact across the whole range, so the
    // clamped step can never overshoot the target or wrap past 0 / all-ones.
    always_comb begin
        diff     = $signed({1'b0, tgt_m}) - $signed({1'b0, m_out});
        mag      = diff[MLEN] ? $unsigned(-diff) : $unsigned(diff);
        step_amt = (mag > STEP_X) ? STEP_X : mag;
        m_next   = diff[MLEN] ? (m_out - step_amt[MLEN-1:0])
                              : (m_out + step_amt[MLEN-1:0]);
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_out     <= M_INIT;
            n_out     <= N_INIT;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            tgt_m     <= '0;
            tgt_n     <= '0;
            hold_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tgt_m     <= req_m;
                        tgt_n     <= req_n;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT_EDGE;
                    end
                end
                WAIT_EDGE: begin
                    // n lands only here, so it never moves while m is ramping.
                    if (step_evt) begin
                        n_out    <= tgt_n;
                        hold_cnt <= '0;
                        if (m_out == tgt_m) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (step_evt) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            m_out    <= m_next;
                            if (m_next == tgt_m) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fracdiv_cfg_ctrl.sv
// tb/tb_fracdiv_cfg_ctrl.sv - directed vector bench for fracdiv_cfg_ctrl
module tb_fracdiv_cfg_ctrl;

    logic        clk_fast = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_clk = 1'b0;

    logic        req_valid = 1'b0;
    logic [15:0] req_m = '0;
    logic [15:0] req_n = '0;
    logic        req_ready;
    logic [15:0] m_out;
    logic [15:0] n_out;
    logic        busy;
    logic        done;
    logic        timeout_evt;

    logic        req_valid16 = 1'b0;
    logic [15:0] req_m16 = '0;
    logic [15:0] req_n16 = '0;
    logic        req_ready16;
    logic [15:0] m_out16;
    logic [15:0] n_out16;
    logic        busy16;
    logic        done16;
    logic        tmo16;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int tmo_seen = 0;

    typedef struct {
        logic [15:0] m;
        logic [15:0] n;
        int          nt;
    } vec_t;

    vec_t vecs[4];

    always #5 clk_fast = ~clk_fast;

    fracdiv_cfg_ctrl #(
        .STEP(1), .HOLD_EDGES(2), .TMO_LEN(8)
    ) dut (
        .clk_fast(clk_fast), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_n(req_n), .div_clk(div_clk), .m_out(m_out), .n_out(n_out),
        .busy(busy), .done(done), .timeout_evt(timeout_evt)
    );

    fracdiv_cfg_ctrl #(
        .STEP(16), .HOLD_EDGES(2), .TMO_LEN(8)
    ) dut16 (
        .clk_fast(clk_fast), .rst_n(rst_n), .req_valid(req_valid16), .req_ready(req_ready16),
        .req_m(req_m16), .req_n(req_n16), .div_clk(div_clk), .m_out(m_out16), .n_out(n_out16),
        .busy(busy16), .done(done16), .timeout_evt(tmo16)
    );

    always @(negedge clk_fast) begin
        if (done) done_cnt++;
        if (timeout_evt) tmo_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic toggle_div();
        @(negedge clk_fast);
        div_clk = ~div_clk;
        @(negedge clk_fast);
    endtask

    task automatic send_req(input logic [15:0] m, input logic [15:0] n);
        req_valid = 1'b1;
        req_m = m;
        req_n = n;
        @(negedge clk_fast);
        req_valid = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(req_ready), 32'd0);
    endtask

    // Drives nt divider toggles and checks the slew trajectory for STEP=1,
    // HOLD_EDGES=2: first toggle applies n, then m moves one unit every two.
    task automatic run_req(input logic [15:0] start, input logic [15:0] tgt,
                           input logic [15:0] old_n, input logic [15:0] new_n, input int nt);
        int sgn;
        int e;
        sgn = (tgt >= start) ? 1 : -1;
        chk("n_before_edge", 32'(n_out), 32'(old_n));
        chk("m_before_edge", 32'(m_out), 32'(start));
        for (int k = 1; k <= nt; k++) begin
            toggle_div();
            e = int'(start) + sgn * ((k - 1) / 2);
            chk("m_traj", 32'(m_out), 32'(e[15:0]));
            if (k == 1) chk("n_applied", 32'(n_out), 32'(new_n));
            chk("done_pulse", 32'(done), (k == nt) ? 32'd1 : 32'd0);
            chk("busy_during", 32'(busy), 32'd1);
            if (k != nt) repeat (2) @(negedge clk_fast);
        end
        exp_done++;
    endtask

    task automatic finish_idle();
        @(negedge clk_fast);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        logic [15:0] cur_m;
        logic [15:0] cur_n;
        logic [15:0] e16a[9];
        logic [15:0] e16b[7];
        int bad;
        int cyc;

        vecs[0] = '{16'd103, 16'h4000, 9};
        vecs[1] = '{16'd100, 16'h1234, 7};
        vecs[2] = '{16'd100, 16'h1234, 1};
        vecs[3] = '{16'd99,  16'h8000, 3};
        e16a = '{16'd99, 16'd99, 16'd83, 16'd83, 16'd67, 16'd67, 16'd51, 16'd51, 16'd40};
        e16b = '{16'd40, 16'd40, 16'd24, 16'd24, 16'd8, 16'd8, 16'd0};

        // Reset state
        repeat (3) @(negedge clk_fast);
        rst_n = 1'b1;
        @(negedge clk_fast);
        chk("rst_m", 32'(m_out), 32'd99);
        chk("rst_n_out", 32'(n_out), 32'h8000);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(timeout_evt), 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (done || timeout_evt || busy) bad++;
            @(negedge clk_fast);
        end
        chk("idle_quiet_100", 32'(bad), 32'd0);

        // Table-driven requests on the STEP=1 instance
        cur_m = 16'd99;
        cur_n = 16'h8000;
        for (int v = 0; v < 4; v++) begin
            send_req(vecs[v].m, vecs[v].n);
            run_req(cur_m, vecs[v].m, cur_n, vecs[v].n, vecs[v].nt);
            finish_idle();
            cur_m = vecs[v].m;
            cur_n = vecs[v].n;
        end
        chk("no_tmo_in_vectors", 32'(tmo_seen), 32'd0);

        // STEP=16 instance: clamp on the last step, then down to 0 without wrap
        req_valid16 = 1'b1; req_m16 = 16'd40; req_n16 = 16'h0400;
        @(negedge clk_fast);
        req_valid16 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            toggle_div();
            chk("s16_down_m", 32'(m_out16), 32'(e16a[k]));
            if (k == 0) chk("s16_n", 32'(n_out16), 32'h0400);
            chk("s16_done", 32'(done16), (k == 8) ? 32'd1 : 32'd0);
            repeat (2) @(negedge clk_fast);
        end
        chk("s16_ready", 32'(req_ready16), 32'd1);
        req_valid16 = 1'b1; req_m16 = 16'd0; req_n16 = 16'h0400;
        @(negedge clk_fast);
        req_valid16 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            toggle_div();
            chk("s16_zero_m", 32'(m_out16), 32'(e16b[k]));
            chk("s16_zero_done", 32'(done16), (k == 6) ? 32'd1 : 32'd0);
            repeat (2) @(negedge clk_fast);
        end
        chk("s16_zero_busy", 32'(busy16), 32'd0);

        // Timeout with div_clk held constant: 2^8-1 cycles for the bench instance
        send_req(16'd99, 16'h0000);
        cyc = 0;
        while (!timeout_evt && cyc < 1000) begin
            @(negedge clk_fast);
            cyc++;
        end
        chk("tmo_latency", 32'(cyc), 32'd255);
        chk("tmo_n_not_yet", 32'(n_out), 32'h8000);
        @(negedge clk_fast);
        chk("tmo_n_applied", 32'(n_out), 32'h0000);
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_pulse_width", 32'(timeout_evt), 32'd0);
        chk("tmo_m", 32'(m_out), 32'd99);
        exp_done++;
        finish_idle();
        chk("tmo_count", 32'(tmo_seen), 32'd1);

        // req_valid held through a busy request: second value waits for IDLE
        send_req(16'd101, 16'h8000);
        req_valid = 1'b1; req_m = 16'd10; req_n = 16'h0100;
        run_req(16'd99, 16'd101, 16'h0000, 16'h8000, 5);
        chk("bp_ready_in_done", 32'(req_ready), 32'd0);
        @(negedge clk_fast);
        chk("bp_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk_fast);
        chk("bp_accepted", 32'(busy), 32'd1);
        chk("bp_not_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        run_req(16'd101, 16'd10, 16'h8000, 16'h0100, 183);
        finish_idle();

        // Asynchronous reset mid-ramp
        rst_n = 1'b0;
        div_clk = 1'b0;
        @(negedge clk_fast);
        rst_n = 1'b1;
        @(negedge clk_fast);
        send_req(16'd103, 16'h4000);
        for (int k = 0; k < 5; k++) begin
            toggle_div();
            repeat (2) @(negedge clk_fast);
        end
        chk("mid_ramp_m", 32'(m_out), 32'd101);
        #2;
        rst_n = 1'b0;
        div_clk = 1'b0;
        #1;
        chk("arst_m", 32'(m_out), 32'd99);
        chk("arst_n", 32'(n_out), 32'h8000);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        @(negedge clk_fast);
        rst_n = 1'b1;
        @(negedge clk_fast);
        send_req(16'd100, 16'h2222);
        run_req(16'd99, 16'd100, 16'h8000, 16'h2222, 3);
        finish_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
